layer_4_input_packer: RTL and testbench

LAYER_4_INPUT_PACKER -- requirements
Module: layer_4_input_packer

---
 rtl/layer_4_input_packer.sv | 105 ++++++++++
 tb/tb_layer_4_input_packer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_4_input_packer.sv
// Packs NUM_CH serial channel words per pixel into one wide word and tracks col/row framing.
// Optional LAYER_4_PACKER_SOF_RESYNC_EN adds sof_in to restart framing mid-stream.
module layer_4_input_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
`ifdef LAYER_4_PACKER_SOF_RESYNC_EN
  input  logic                         sof_in,
`endif
  output logic [DATA_WIDTH*NUM_CH-1:0] data_out,
  output logic                         valid_out,
  output logic                         frame_done
);

  localparam int CH_W  = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1;
  localparam int POS_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int PIX_W = DATA_WIDTH * NUM_CH;

  logic [CH_W-1:0]  r_ch;
  logic [POS_W-1:0] r_col;
  logic [POS_W-1:0] r_row;
  logic [PIX_W-1:0] r_fill;
  logic [PIX_W-1:0] r_data_out;
  logic             r_valid_out;
  logic             r_frame_done;

  logic             w_last_ch;
  logic             w_last_col;
  logic             w_last_row;
  logic             w_sof;
  logic [PIX_W-1:0] w_pixel;

  assign w_last_ch  = (r_ch  == CH_W'(NUM_CH - 1));
  assign w_last_col = (r_col == POS_W'(IMG_SIZE - 1));
  assign w_last_row = (r_row == POS_W'(IMG_SIZE - 1));

`ifdef LAYER_4_PACKER_SOF_RESYNC_EN
  assign w_sof = valid_in & sof_in;
`else
  assign w_sof = 1'b0;
`endif

  // Fill register with the incoming word merged in, so the last word reaches
  // data_out on the same edge it is accepted.
  // NOTE: every always_comb target gets a full default first so no latch is inferred.
  always_comb begin
    w_pixel = r_fill;
    w_pixel[int'(r_ch)*DATA_WIDTH +: DATA_WIDTH] = data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      // NOTE: the fill register is cleared on reset so a partial pixel can never leak out.
      r_ch         <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_fill       <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      if (w_sof) begin
        // Restart framing: this word becomes channel 0 of pixel (0,0).
        r_fill[DATA_WIDTH-1:0] <= data_in;
        r_ch                   <= (NUM_CH > 1) ? CH_W'(1) : '0;
        r_col                  <= '0;
        r_row                  <= '0;
      end else if (valid_in) begin
        r_fill <= w_pixel;
        if (w_last_ch) begin
          r_ch        <= '0;
          r_data_out  <= w_pixel;
          r_valid_out <= 1'b1;
          if (w_last_col) begin
            r_col <= '0;
            if (w_last_row) begin
              r_row        <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_row <= r_row + POS_W'(1);
            end
          end else begin
            r_col <= r_col + POS_W'(1);
          end
        end else begin
          r_ch <= r_ch + CH_W'(1);
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_layer_4_input_packer.sv
// Directed bench for layer_4_input_packer; IMG_SIZE is reduced to 4 so full frames stay short.
// Define LAYER_4_PACKER_SOF_RESYNC_EN to also exercise the sof_in resync path.
module tb_layer_4_input_packer;

  localparam int DW  = 32;
  localparam int NCH = 32;
  localparam int IMG = 4;
  localparam int NPX = IMG * IMG;

  logic              Clk = 1'b0;
  logic              Rst = 1'b1;
  logic [DW-1:0]     data_in = '0;
  logic              valid_in = 1'b0;
  logic [DW*NCH-1:0] data_out;
  logic              valid_out;
  logic              frame_done;
`ifdef LAYER_4_PACKER_SOF_RESYNC_EN
  logic              sof_in = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int vo_count  = 0;
  int fd_count  = 0;
  int fd_at     = 0;
  int fd_orphan = 0;

  always #5 Clk = ~Clk;

  layer_4_input_packer #(
    .DATA_WIDTH(DW),
    .NUM_CH    (NCH),
    .IMG_SIZE  (IMG)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
`ifdef LAYER_4_PACKER_SOF_RESYNC_EN
    .sof_in    (sof_in),
`endif
    .data_out  (data_out),
    .valid_out (valid_out),
    .frame_done(frame_done)
  );

  // Output monitor, sampled just after each rising edge.
  always @(posedge Clk) begin
    #1;
    if (valid_out) vo_count++;
    if (frame_done) begin
      fd_count++;
      fd_at = vo_count;
      if (!valid_out) fd_orphan++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One input cycle, driven on the falling edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d);
    @(negedge Clk);
    valid_in = v;
    data_in  = d;
`ifdef LAYER_4_PACKER_SOF_RESYNC_EN
    sof_in   = 1'b0;
`endif
  endtask

  task automatic check_pixel(input string tag, input logic [DW-1:0] base, input bit incr);
    logic [DW-1:0] exp;
    for (int k = 0; k < NCH; k++) begin
      exp = incr ? base + DW'(k) : base;
      check($sformatf("%s slot%0d", tag, k), 64'(data_out[k*DW +: DW]), 64'(exp));
    end
  endtask

  // One-cycle reset with a live word on the bus, which must be ignored.
  task automatic do_reset();
    @(negedge Clk);
    Rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hDEADBEEF;
    @(negedge Clk);
    Rst       = 1'b0;
    valid_in  = 1'b0;
    vo_count  = 0;
    fd_count  = 0;
    fd_at     = 0;
    fd_orphan = 0;
  endtask

  task automatic send_pixel(input logic [DW-1:0] base);
    for (int k = 0; k < NCH; k++) cyc(1'b1, base + DW'(k));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    check("reset valid_out", 64'(valid_out), 64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset data_out slot0", 64'(data_out[DW-1:0]), 64'd0);
    check("reset data_out slot31", 64'(data_out[31*DW +: DW]), 64'd0);

    // Single pixel, first word on the first cycle after reset release
    Rst      = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'h3F800000;
    for (int k = 1; k < NCH; k++) cyc(1'b1, 32'h3F800000 + DW'(k));
    check("single no early valid", 64'(vo_count), 64'd0);
    cyc(1'b0, '0);
    check("single valid_out", 64'(valid_out), 64'd1);
    check("single frame_done", 64'(frame_done), 64'd0);
    check_pixel("single", 32'h3F800000, 1'b1);
    cyc(1'b0, '0);
    check("single pulse width", 64'(valid_out), 64'd0);
    check("single pulse count", 64'(vo_count), 64'd1);

    // Same pixel with valid_in toggling every cycle
    for (int k = 0; k < NCH; k++) begin
      cyc(1'b1, 32'h3F800000 + DW'(k));
      if (k == NCH - 1) check("gap no early valid", 64'(vo_count), 64'd1);
      cyc(1'b0, '0);
    end
    check("gap valid_out", 64'(valid_out), 64'd1);
    check("gap pulse count", 64'(vo_count), 64'd2);
    check_pixel("gap", 32'h3F800000, 1'b1);
    cyc(1'b0, '0);
    check("gap pulse width", 64'(valid_out), 64'd0);

    // Two full frames back-to-back from reset
    do_reset();
    for (int p = 0; p < NPX; p++) send_pixel(DW'(p) << 8);
    cyc(1'b0, '0);
    check("frame1 pixels", 64'(vo_count), 64'(NPX));
    check("frame1 done count", 64'(fd_count), 64'd1);
    check("frame1 done pixel", 64'(fd_at), 64'(NPX));
    check("frame1 done with valid", 64'(frame_done), 64'd1);
    check("frame1 last slot5", 64'(data_out[5*DW +: DW]), 64'(((NPX - 1) << 8) + 5));
    cyc(1'b0, '0);
    check("frame1 done width", 64'(frame_done), 64'd0);
    for (int p = 0; p < NPX; p++) send_pixel(32'h00A00000 + (DW'(p) << 8));
    cyc(1'b0, '0);
    check("frame2 pixels", 64'(vo_count), 64'(2 * NPX));
    check("frame2 done count", 64'(fd_count), 64'd2);
    check("frame2 done pixel", 64'(fd_at), 64'(2 * NPX));
    check("frame done orphans", 64'(fd_orphan), 64'd0);

    // Reset in the middle of a pixel
    do_reset();
    for (int k = 0; k < 17; k++) cyc(1'b1, 32'h12340000 + DW'(k));
    @(negedge Clk);
    Rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hCAFEF00D;
    @(negedge Clk);
    check("midrst data_out cleared", 64'(data_out[DW-1:0]), 64'd0);
    check("midrst valid_out", 64'(valid_out), 64'd0);
    Rst      = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hBF000000;
    for (int k = 1; k < NCH; k++) cyc(1'b1, 32'hBF000000);
    check("midrst no early valid", 64'(vo_count), 64'd0);
    cyc(1'b0, '0);
    check("midrst valid_out", 64'(valid_out), 64'd1);
    check_pixel("midrst", 32'hBF000000, 1'b0);

    // Output holds pixel A while pixel B is partially filled
    send_pixel(32'h40000000);
    cyc(1'b0, '0);
    check("hold A valid", 64'(vo_count), 64'd2);
    for (int k = 0; k < 10; k++) cyc(1'b1, 32'h50000000 + DW'(k));
    cyc(1'b0, '0);
    check("hold valid_out", 64'(valid_out), 64'd0);
    check("hold pulse count", 64'(vo_count), 64'd2);
    check_pixel("hold", 32'h40000000, 1'b1);

`ifdef LAYER_4_PACKER_SOF_RESYNC_EN
    // Resync: two pixels advance col, then a partial pixel is abandoned by sof_in
    do_reset();
    send_pixel(32'h60000000);
    send_pixel(32'h61000000);
    for (int k = 0; k < 5; k++) cyc(1'b1, 32'h70000000 + DW'(k));
    @(negedge Clk);
    valid_in = 1'b1;
    data_in  = 32'h11111111;
    sof_in   = 1'b1;
    for (int k = 1; k < NCH; k++) cyc(1'b1, 32'h22220000 + DW'(k));
    check("sof no early valid", 64'(vo_count), 64'd2);
    cyc(1'b0, '0);
    check("sof valid_out", 64'(valid_out), 64'd1);
    check("sof pulse count", 64'(vo_count), 64'd3);
    check("sof slot0", 64'(data_out[DW-1:0]), 64'h11111111);
    check("sof slot1", 64'(data_out[DW +: DW]), 64'h22220001);
    check("sof slot31", 64'(data_out[31*DW +: DW]), 64'h2222001F);
    for (int p = 1; p < NPX; p++) send_pixel(32'h80000000 + (DW'(p) << 8));
    cyc(1'b0, '0);
    check("sof frame done count", 64'(fd_count), 64'd1);
    check("sof frame done pixel", 64'(fd_at), 64'(NPX + 2));
`endif

    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
